// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: state encoding, default sizes, clog2.
package fifo_pkg;

    localparam int unsigned DefWidth    = 4;
    localparam int unsigned DefMaxBurst = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning last_i+1, last_i+2, ... modulo NumReq.
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdW    = clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    last_i,
    output logic [IdW-1:0]    idx_o,
    output logic              valid_o
);

    logic [IdW-1:0] cand;

    // Scan farthest-first so the nearest requester after last_i wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = NumReq; k >= 1; k--) begin
            cand = IdW'((32'(last_i) + k) % NumReq);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO memory write port among NumReq producers,
// with bounded bursts and stall on full; beats are accepted combinationally.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter  int unsigned Width    = DefWidth,
    parameter  int unsigned NumReq   = 4,
    parameter  int unsigned MaxBurst = DefMaxBurst,
    localparam int unsigned IdW      = clog2(NumReq),
    localparam int unsigned CntW     = clog2(MaxBurst + 1)
) (
    input  logic                    w_clk,
    input  logic                    w_rst,
    input  logic [NumReq-1:0]       req,
    input  logic [NumReq-1:0]       lock,
    input  logic [NumReq*Width-1:0] data_in,
    input  logic                    full,
    output logic [NumReq-1:0]       ack,
    output logic [Width-1:0]        w_data,
    output logic                    w_en,
    output logic [IdW-1:0]          grant_id,
    output logic                    busy
);

    state_e          state_q, state_d;
    logic [IdW-1:0]  grant_q, grant_d;
    logic [IdW-1:0]  rr_last_q, rr_last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdW-1:0]  pick_idx;
    logic            pick_valid;
    logic            accept;
    logic            rel_c;
    logic [Width-1:0] slice [NumReq];

    for (genvar i = 0; i < NumReq; i++) begin : g_slice
        assign slice[i] = data_in[i*Width +: Width];
    end

    rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .req_i   (req),
        .last_i  (rr_last_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Zero-latency write handshake for the current owner.
    assign busy     = (state_q == GRANT);
    assign accept   = busy & req[grant_q] & ~full;
    assign w_en     = accept;
    assign ack      = accept ? (NumReq'(1) << grant_q) : '0;
    assign w_data   = busy ? slice[grant_q] : '0;
    assign grant_id = grant_q;

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            cnt_q     <= '0;
            rr_last_q <= IdW'(NumReq - 1);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        rel_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid && !full) begin
                    state_d = GRANT;
                    grant_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (accept) cnt_d = cnt_q + CntW'(1);
                // Full alone never releases; only a dropped req or a finished burst does.
                rel_c = !req[grant_q] ||
                        (accept && (!lock[grant_q] ||
                                    ((cnt_q + CntW'(1)) == CntW'(MaxBurst))));
                if (rel_c) begin
                    state_d   = IDLE;
                    rr_last_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed vector bench for fifo_write_arbiter (Width=4, NumReq=4, MaxBurst=4).
module tb_fifo_write_arbiter;

    logic        w_clk = 1'b0;
    logic        w_rst = 1'b0;
    logic [3:0]  req   = '0;
    logic [3:0]  lock  = '0;
    logic [15:0] data_in = '0;
    logic        full  = 1'b0;
    logic [3:0]  ack;
    logic [3:0]  w_data;
    logic        w_en;
    logic [1:0]  grant_id;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 w_clk = ~w_clk;

    fifo_write_arbiter #(
        .Width    (4),
        .NumReq   (4),
        .MaxBurst (4)
    ) dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .req      (req),
        .lock     (lock),
        .data_in  (data_in),
        .full     (full),
        .ack      (ack),
        .w_data   (w_data),
        .w_en     (w_en),
        .grant_id (grant_id),
        .busy     (busy)
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic        full;
        logic [15:0] din;
        logic        busy;
        logic [1:0]  gid;
        logic [3:0]  ack;
        logic        wen;
        logic [3:0]  wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] lk,
                                input logic fl, input logic [15:0] d, input logic b,
                                input logic [1:0] g, input logic [3:0] a, input logic we,
                                input logic [3:0] wd);
        vec_t v;
        v.rst = rst; v.req = rq; v.lock = lk; v.full = fl; v.din = d;
        v.busy = b; v.gid = g; v.ack = a; v.wen = we; v.wdata = wd;
        return v;
    endfunction

    task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] lk,
                       input logic fl, input logic [15:0] d, input logic b,
                       input logic [1:0] g, input logic [3:0] a, input logic we,
                       input logic [3:0] wd);
        vecs.push_back(mk(rst, rq, lk, fl, d, b, g, a, we, wd));
    endtask

    // Drive one cycle of inputs after the edge, compare mid-cycle. grant_id only
    // matters while busy (or in reset, where it must read 0).
    task automatic apply(input vec_t v, input string name);
        logic [11:0] got;
        logic [11:0] exp;
        @(posedge w_clk);
        #1;
        w_rst = v.rst; req = v.req; lock = v.lock; full = v.full; data_in = v.din;
        @(negedge w_clk);
        got = {busy, (v.busy || !v.rst) ? grant_id : 2'b00, ack, w_en, w_data};
        exp = {v.busy, v.gid, v.ack, v.wen, v.wdata};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got busy/gid/ack/wen/wdata=%b_%b_%b_%b_%h expected %b_%b_%b_%b_%h",
                     name, got[11], got[10:9], got[8:5], got[4], got[3:0],
                     exp[11], exp[10:9], exp[8:5], exp[4], exp[3:0]);
        end
    endtask

    initial begin
        int waited;
        // A: single producer, 4-beat burst then next grant after one bubble
        add(0, 4'h1, 4'h1, 0, 16'h000A, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h1, 4'h1, 0, 16'h000A, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h1, 4'h1, 0, 16'h000A, 1, 0, 4'h1, 1, 4'hA);
        add(1, 4'h1, 4'h1, 0, 16'h000B, 1, 0, 4'h1, 1, 4'hB);
        add(1, 4'h1, 4'h1, 0, 16'h000C, 1, 0, 4'h1, 1, 4'hC);
        add(1, 4'h1, 4'h1, 0, 16'h000D, 1, 0, 4'h1, 1, 4'hD);
        add(1, 4'h1, 4'h1, 0, 16'h000E, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h1, 4'h0, 0, 16'h000E, 1, 0, 4'h1, 1, 4'hE);
        add(1, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 0, 4'h0);
        // B: all requesting, no lock -> single-beat grants 0,1,2,3,0
        add(0, 4'hF, 4'h0, 0, 16'h4321, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 1, 0, 4'h1, 1, 4'h1);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 1, 1, 4'h2, 1, 4'h2);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 1, 2, 4'h4, 1, 4'h3);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 1, 3, 4'h8, 1, 4'h4);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'hF, 4'h0, 0, 16'h4321, 1, 0, 4'h1, 1, 4'h1);
        // C: producer 2 locked burst, full for 3 cycles after beat 1
        add(0, 4'h4, 4'h4, 0, 16'h0500, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h4, 4'h4, 0, 16'h0500, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h4, 4'h4, 0, 16'h0500, 1, 2, 4'h4, 1, 4'h5);
        add(1, 4'h4, 4'h4, 1, 16'h0600, 1, 2, 4'h0, 0, 4'h6);
        add(1, 4'h4, 4'h4, 1, 16'h0600, 1, 2, 4'h0, 0, 4'h6);
        add(1, 4'h4, 4'h4, 1, 16'h0600, 1, 2, 4'h0, 0, 4'h6);
        add(1, 4'h4, 4'h4, 0, 16'h0600, 1, 2, 4'h4, 1, 4'h6);
        add(1, 4'h4, 4'h4, 0, 16'h0700, 1, 2, 4'h4, 1, 4'h7);
        add(1, 4'h4, 4'h4, 0, 16'h0800, 1, 2, 4'h4, 1, 4'h8);
        add(1, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 0, 4'h0);
        // D: full in IDLE blocks the grant
        add(0, 4'h2, 4'h0, 1, 16'h0090, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h2, 4'h0, 1, 16'h0090, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h2, 4'h0, 1, 16'h0090, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h2, 4'h0, 1, 16'h0090, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h2, 4'h0, 0, 16'h0090, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h2, 4'h0, 0, 16'h0090, 1, 1, 4'h2, 1, 4'h9);
        add(1, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 0, 4'h0);
        // E: reset mid-burst of producer 3 (two beats done), then 0 wins first
        add(0, 4'h8, 4'h8, 0, 16'hB000, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h8, 4'h8, 0, 16'hB000, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h8, 4'h8, 0, 16'hB000, 1, 3, 4'h8, 1, 4'hB);
        add(1, 4'h8, 4'h8, 0, 16'hC000, 1, 3, 4'h8, 1, 4'hC);
        add(0, 4'h9, 4'h8, 0, 16'hC00D, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h9, 4'h8, 0, 16'hC00D, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h9, 4'h8, 0, 16'hC00D, 1, 0, 4'h1, 1, 4'hD);
        add(1, 4'h9, 4'h8, 0, 16'hC00D, 0, 0, 4'h0, 0, 4'h0);
        add(1, 4'h9, 4'h8, 0, 16'hC00D, 1, 3, 4'h8, 1, 4'hC);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // F: owner 0 drops req after one locked beat; producer 1 follows after one bubble
        apply(mk(0, 4'h3, 4'h3, 0, 16'h0021, 0, 0, 4'h0, 0, 4'h0), "drop_rst");
        apply(mk(1, 4'h3, 4'h3, 0, 16'h0021, 0, 0, 4'h0, 0, 4'h0), "drop_idle");
        apply(mk(1, 4'h3, 4'h3, 0, 16'h0021, 1, 0, 4'h1, 1, 4'h1), "drop_beat1");
        apply(mk(1, 4'h2, 4'h3, 0, 16'h0021, 1, 0, 4'h0, 0, 4'h1), "drop_release");
        waited = 0;
        while (waited < 8) begin
            @(posedge w_clk);
            @(negedge w_clk);
            waited++;
            if (ack == 4'h2) break;
        end
        n_cmp++;
        if (ack != 4'h2 || waited != 2 || grant_id != 2'd1 || w_data != 4'h2) begin
            n_bad++;
            $display("FAIL next_owner: got ack=%b after %0d cycles gid=%0d wdata=%h, expected ack=0010 after 2 cycles gid=1 wdata=2",
                     ack, waited, grant_id, w_data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
